// File: rtl/uart_rx_pkg.sv
// Shared UART RX definitions: default frame/FIFO parameters and receive-entry layout.
package uart_rx_pkg;

  localparam int unsigned DATA_W_DEF     = 8;
  localparam int unsigned DEPTH_DEF      = 4;
  localparam int unsigned PARITY_EN_DEF  = 0;
  localparam int unsigned PARITY_ODD_DEF = 0;

  // Entry = {frame_err, parity_err, data}; flag offsets are relative to DATA_W.
  localparam int unsigned FLAG_W   = 2;
  localparam int unsigned PERR_OFS = 0;
  localparam int unsigned FERR_OFS = 1;

  typedef struct packed {
    logic                  frame_err;
    logic                  parity_err;
    logic [DATA_W_DEF-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/rx_fifo_sync.sv
// Synchronous show-ahead FIFO; read data comes straight from storage at the read pointer.
module rx_fifo_sync #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    wptr;
  logic [CW-1:0]    count;
  logic             wr_c;
  logic             rd_c;

  // A full FIFO still accepts a write when the same cycle pops.
  assign rd_c = pop && !empty;
  assign wr_c = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (wr_c) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + AW'(1);
      end
      if (rd_c) rptr <= rptr + AW'(1);
      case ({wr_c, rd_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign level = count;

endmodule

// File: rtl/uart_rx_deser_fifo.sv
// UART RX deserialiser: LSB-first frame shift register, framing/parity check,
// and a receive FIFO with sticky overflow.
module uart_rx_deser_fifo
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned PARITY_EN  = PARITY_EN_DEF,
  parameter int unsigned PARITY_ODD = PARITY_ODD_DEF
) (
  input  logic                     CLOCK,
  input  logic                     reset_n,
  input  logic                     Rx,
  input  logic                     shift,
  input  logic                     load_buffer,
  input  logic                     Rd_en,
  input  logic                     clr_ovrflw,
  output logic [DATA_W-1:0]        out,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     d_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int unsigned FRAME_W = DATA_W + PARITY_EN;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
  localparam int unsigned ENT_W   = DATA_W + FLAG_W;

  logic [FRAME_W-1:0] sr_q;
  logic [FRAME_W-1:0] sr_c;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_c;
  logic               perr_c;
  logic               ferr_c;
  logic               drop_c;
  logic               empty;
  logic               ovf_q;
  logic [ENT_W-1:0]   wdata;
  logic [ENT_W-1:0]   rdata;

  // Next frame state includes this cycle's shift so a same-cycle load sees it.
  always_comb begin
    sr_c  = sr_q;
    cnt_c = cnt_q;
    if (shift) begin
      sr_c = {Rx, sr_q[FRAME_W-1:1]};
      if (cnt_q != CNT_W'(FRAME_W + 1)) cnt_c = cnt_q + CNT_W'(1);
    end
  end

  assign ferr_c = (cnt_c != CNT_W'(FRAME_W));
  assign perr_c = (PARITY_EN != 0) && ((^sr_c) != 1'(PARITY_ODD));
  assign wdata  = {ferr_c, perr_c, sr_c[DATA_W-1:0]};
  assign drop_c = load_buffer && full && !Rd_en;

  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sr_q  <= sr_c;
      cnt_q <= load_buffer ? '0 : cnt_c;
      if (clr_ovrflw)  ovf_q <= 1'b0;
      else if (drop_c) ovf_q <= 1'b1;
    end
  end

  rx_fifo_sync #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLOCK),
    .rst_n (reset_n),
    .push  (load_buffer),
    .pop   (Rd_en),
    .wdata (wdata),
    .rdata (rdata),
    .empty (empty),
    .full  (full),
    .level (level)
  );

  assign out        = rdata[DATA_W-1:0];
  assign parity_err = rdata[DATA_W + PERR_OFS];
  assign frame_err  = rdata[DATA_W + FERR_OFS];
  assign d_valid    = !empty;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_rx_deser_fifo.sv
// Directed bench for uart_rx_deser_fifo: default instance plus an even-parity instance
// fed the same stimulus.
module tb_uart_rx_deser_fifo;

  logic       CLOCK;
  logic       reset_n;
  logic       Rx;
  logic       shift;
  logic       load_buffer;
  logic       Rd_en;
  logic       clr_ovrflw;

  logic [7:0] out;
  logic       parity_err, frame_err, d_valid, full, overflow;
  logic [2:0] level;

  logic [7:0] p_out;
  logic       p_parity_err, p_frame_err, p_d_valid, p_full, p_overflow;
  logic [2:0] p_level;

  int tests = 0;
  int fails = 0;

  uart_rx_deser_fifo u_dut (
    .CLOCK(CLOCK), .reset_n(reset_n), .Rx(Rx), .shift(shift),
    .load_buffer(load_buffer), .Rd_en(Rd_en), .clr_ovrflw(clr_ovrflw),
    .out(out), .parity_err(parity_err), .frame_err(frame_err),
    .d_valid(d_valid), .full(full), .level(level), .overflow(overflow)
  );

  uart_rx_deser_fifo #(.PARITY_EN(1), .PARITY_ODD(0)) u_par (
    .CLOCK(CLOCK), .reset_n(reset_n), .Rx(Rx), .shift(shift),
    .load_buffer(load_buffer), .Rd_en(Rd_en), .clr_ovrflw(clr_ovrflw),
    .out(p_out), .parity_err(p_parity_err), .frame_err(p_frame_err),
    .d_valid(p_d_valid), .full(p_full), .level(p_level), .overflow(p_overflow)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    int         nbits;
    logic [8:0] data;
    logic       push;
    logic       rd;
    logic       clr;
    logic       exp_valid;
    int         exp_level;
    logic       exp_full;
    logic       exp_ovf;
    logic [7:0] exp_out;
    logic       exp_ferr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // Shift nbits of data LSB-first; strobes ride on the last shift (or a lone cycle).
  task automatic do_frame(input int nbits, input logic [8:0] data,
                          input logic push, input logic rd, input logic clr);
    if (nbits == 0) begin
      load_buffer = push; Rd_en = rd; clr_ovrflw = clr;
      tick();
    end else begin
      for (int i = 0; i < nbits; i++) begin
        shift       = 1'b1;
        Rx          = data[i];
        load_buffer = push && (i == nbits - 1);
        Rd_en       = rd   && (i == nbits - 1);
        clr_ovrflw  = clr  && (i == nbits - 1);
        tick();
      end
    end
    shift = 1'b0; Rx = 1'b0; load_buffer = 1'b0; Rd_en = 1'b0; clr_ovrflw = 1'b0;
  endtask

  function automatic vec_t mk(input int nb, input logic [8:0] d, input logic p,
                              input logic r, input logic c, input logic ev, input int el,
                              input logic ef, input logic eo, input logic [7:0] eout,
                              input logic eferr);
    vec_t v;
    v.nbits = nb; v.data = d; v.push = p; v.rd = r; v.clr = c;
    v.exp_valid = ev; v.exp_level = el; v.exp_full = ef; v.exp_ovf = eo;
    v.exp_out = eout; v.exp_ferr = eferr;
    return v;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out"},   32'(out), 32'h0);
    chk({tag, "_perr"},  32'(parity_err), 32'h0);
    chk({tag, "_ferr"},  32'(frame_err), 32'h0);
    chk({tag, "_valid"}, 32'(d_valid), 32'h0);
    chk({tag, "_full"},  32'(full), 32'h0);
    chk({tag, "_level"}, 32'(level), 32'h0);
    chk({tag, "_ovf"},   32'(overflow), 32'h0);
  endtask

  initial begin
    reset_n = 1'b0; Rx = 1'b0; shift = 1'b0; load_buffer = 1'b0;
    Rd_en = 1'b0; clr_ovrflw = 1'b0;

    //                nb  data    p  r  c   v  lvl f  o  out    fe
    tbl.push_back(mk(8, 9'h0A5, 1, 0, 0,  1, 1,  0, 0, 8'hA5, 0));
    tbl.push_back(mk(0, 9'h000, 0, 1, 0,  0, 0,  0, 0, 8'h00, 0));
    tbl.push_back(mk(6, 9'h015, 1, 0, 0,  1, 1,  0, 0, 8'h56, 1));
    tbl.push_back(mk(0, 9'h000, 0, 1, 0,  0, 0,  0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 9'h000, 0, 1, 0,  0, 0,  0, 0, 8'h00, 0));
    tbl.push_back(mk(8, 9'h001, 1, 0, 0,  1, 1,  0, 0, 8'h01, 0));
    tbl.push_back(mk(8, 9'h002, 1, 0, 0,  1, 2,  0, 0, 8'h01, 0));
    tbl.push_back(mk(8, 9'h003, 1, 0, 0,  1, 3,  0, 0, 8'h01, 0));
    tbl.push_back(mk(8, 9'h004, 1, 0, 0,  1, 4,  1, 0, 8'h01, 0));
    tbl.push_back(mk(8, 9'h005, 1, 0, 0,  1, 4,  1, 1, 8'h01, 0));
    tbl.push_back(mk(0, 9'h000, 0, 1, 0,  1, 3,  0, 1, 8'h02, 0));
    tbl.push_back(mk(0, 9'h000, 0, 1, 0,  1, 2,  0, 1, 8'h03, 0));
    tbl.push_back(mk(0, 9'h000, 0, 1, 0,  1, 1,  0, 1, 8'h04, 0));
    tbl.push_back(mk(0, 9'h000, 0, 1, 0,  0, 0,  0, 1, 8'h00, 0));
    tbl.push_back(mk(0, 9'h000, 0, 0, 1,  0, 0,  0, 0, 8'h00, 0));
    tbl.push_back(mk(8, 9'h011, 1, 0, 0,  1, 1,  0, 0, 8'h11, 0));
    tbl.push_back(mk(8, 9'h022, 1, 0, 0,  1, 2,  0, 0, 8'h11, 0));
    tbl.push_back(mk(8, 9'h033, 1, 0, 0,  1, 3,  0, 0, 8'h11, 0));
    tbl.push_back(mk(8, 9'h044, 1, 0, 0,  1, 4,  1, 0, 8'h11, 0));
    tbl.push_back(mk(8, 9'h066, 1, 0, 1,  1, 4,  1, 0, 8'h11, 0));
    tbl.push_back(mk(8, 9'h055, 1, 1, 0,  1, 4,  1, 0, 8'h22, 0));
    tbl.push_back(mk(0, 9'h000, 0, 1, 0,  1, 3,  0, 0, 8'h33, 0));
    tbl.push_back(mk(0, 9'h000, 0, 1, 0,  1, 2,  0, 0, 8'h44, 0));
    tbl.push_back(mk(0, 9'h000, 0, 1, 0,  1, 1,  0, 0, 8'h55, 0));
    tbl.push_back(mk(0, 9'h000, 0, 1, 0,  0, 0,  0, 0, 8'h00, 0));

    #1;
    chk_all_zero("in_reset");
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk_all_zero("after_reset");

    for (int k = 0; k < tbl.size(); k++) begin
      do_frame(tbl[k].nbits, tbl[k].data, tbl[k].push, tbl[k].rd, tbl[k].clr);
      chk($sformatf("v%0d_valid", k), 32'(d_valid), 32'(tbl[k].exp_valid));
      chk($sformatf("v%0d_level", k), 32'(level), 32'(tbl[k].exp_level));
      chk($sformatf("v%0d_full", k), 32'(full), 32'(tbl[k].exp_full));
      chk($sformatf("v%0d_ovf", k), 32'(overflow), 32'(tbl[k].exp_ovf));
      if (tbl[k].exp_valid) begin
        chk($sformatf("v%0d_out", k), 32'(out), 32'(tbl[k].exp_out));
        chk($sformatf("v%0d_ferr", k), 32'(frame_err), 32'(tbl[k].exp_ferr));
        chk($sformatf("v%0d_perr", k), 32'(parity_err), 32'h0);
      end
    end

    // Reset mid-frame with three entries held, head carrying a frame error.
    do_frame(6, 9'h03F, 1, 0, 0);
    do_frame(8, 9'h0F0, 1, 0, 0);
    do_frame(8, 9'h05A, 1, 0, 0);
    chk("pre_rst_level", 32'(level), 32'h3);
    chk("pre_rst_ferr", 32'(frame_err), 32'h1);
    shift = 1'b1; Rx = 1'b1;
    tick(); tick(); tick();
    shift = 1'b0; Rx = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    tick();
    reset_n = 1'b1;
    do_frame(8, 9'h03C, 1, 0, 0);
    chk("post_rst_valid", 32'(d_valid), 32'h1);
    chk("post_rst_level", 32'(level), 32'h1);
    chk("post_rst_out", 32'(out), 32'h3C);
    chk("post_rst_ferr", 32'(frame_err), 32'h0);

    // Even parity on the parity instance: 0x03 with parity 1 is bad, with parity 0 good.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    do_frame(9, 9'h103, 1, 0, 0);
    chk("par1_valid", 32'(p_d_valid), 32'h1);
    chk("par1_out", 32'(p_out), 32'h03);
    chk("par1_perr", 32'(p_parity_err), 32'h1);
    chk("par1_ferr", 32'(p_frame_err), 32'h0);
    do_frame(0, 9'h000, 0, 1, 0);
    do_frame(9, 9'h003, 1, 0, 0);
    chk("par0_level", 32'(p_level), 32'h1);
    chk("par0_out", 32'(p_out), 32'h03);
    chk("par0_perr", 32'(p_parity_err), 32'h0);
    chk("par0_ferr", 32'(p_frame_err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_deser_fifo.md
UART_RX_DESER_FIFO -- requirements
Module: uart_rx_deser_fifo

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_W, 8, data bits per frame, legal range 5..9.
  DEPTH, 4, receive FIFO entries, power of 2, legal range 2..16.
  PARITY_EN, 0, 1 adds one parity bit after the data bits.
  PARITY_ODD, 0, 1 selects odd parity, 0 selects even; ignored when PARITY_EN=0.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  CLOCK  in  1  single clock; all logic on posedge.
  reset_n  in  1  asynchronous, active-low reset.
  Rx  in  1  serial data bit, already synchronised and sampled.
  shift  in  1  strobe: capture Rx as the next frame bit.
  load_buffer  in  1  strobe: frame complete, push it to the FIFO.
  Rd_en  in  1  pop the head entry.
  clr_ovrflw  in  1  clear overflow.
  out  out  DATA_W  head entry data (show-ahead).
  parity_err  out  1  head entry parity flag.
  frame_err  out  1  head entry bit-count flag.
  d_valid  out  1  FIFO not empty.
  full  out  1  FIFO holds DEPTH entries.
  level  out  $clog2(DEPTH)+1  number of entries held.
  overflow  out  1  sticky: a frame was dropped.

Function
REQ-003 FRAME_W SHALL equal DATA_W+PARITY_EN; the shift register SHALL be FRAME_W wide and filled LSB-first: shift loads Rx at the MSB and moves the other bits right by one.
REQ-004 A saturating bit counter SHALL increment on each shift; it SHALL stop at FRAME_W+1 and clear on load_buffer.
REQ-005 When shift and load_buffer are asserted in the same cycle, the pushed frame SHALL include the Rx bit captured in that cycle, and the bit count SHALL be evaluated after that increment.
REQ-006 On load_buffer the block SHALL form one entry: {frame_err, parity_err, data[DATA_W-1:0]}.
  frame_err = (bit count != FRAME_W).
  parity_err = PARITY_EN and (XOR of all FRAME_W bits != PARITY_ODD).
  data = frame bits [DATA_W-1:0].
REQ-007 A push SHALL be accepted if the FIFO is not full, or if it is full and Rd_en pops in the same cycle.
REQ-008 Otherwise the push SHALL be dropped, the FIFO content SHALL be unchanged, and overflow SHALL be set on the next edge.
REQ-009 clr_ovrflw SHALL clear overflow and SHALL take priority over a same-cycle set.
REQ-010 Rd_en while d_valid=1 SHALL advance the read pointer; Rd_en while d_valid=0 SHALL be ignored.
REQ-011 A simultaneous push and pop SHALL leave level unchanged and keep entry order.
REQ-012 out, parity_err and frame_err SHALL show the head entry combinationally from storage, with zero extra latency.
REQ-013 A pushed entry SHALL be visible with d_valid=1 on the cycle after its load_buffer.
REQ-014 Read and write pointers SHALL wrap modulo DEPTH.
REQ-015 full, d_valid and level SHALL be derived from registered state only.

Reset
REQ-016 With reset_n=0 the block SHALL clear, asynchronously: shift register, bit counter, pointers, all storage entries, and overflow.
REQ-017 During and after reset: out=0, parity_err=0, frame_err=0, d_valid=0, full=0, level=0, overflow=0.
REQ-018 A reset asserted mid-frame or with a non-empty FIFO SHALL discard all content, and no flag SHALL survive it.
REQ-019 Deassertion of reset_n is assumed synchronous to CLOCK; the block SHALL react to strobes from the first edge after deassertion.

Structure
REQ-020 The default values of DATA_W, DEPTH, PARITY_EN and PARITY_ODD, and the entry field layout, SHALL live in the shared uart_rx package, and the UART RX FSM SHALL reuse them.
REQ-021 Storage SHALL be one sub-module, rx_fifo_sync, with parameters width DATA_W+2 and depth DEPTH.
REQ-022 Framing, parity and the overflow flag SHALL stay in the top module.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
  - Defaults; shift 8 bits of 0xA5 LSB-first; load_buffer -> next cycle d_valid=1, out=0xA5, parity_err=0, frame_err=0, level=1.
  - PARITY_EN=1, PARITY_ODD=0; shift 0x03 then parity bit 1 -> parity_err=1. Same frame with parity bit 0 -> parity_err=0.
  - Push 5 frames 0x01..0x05, no reads, DEPTH=4 -> full=1, level=4, overflow=1. Pops return 0x01..0x04, then d_valid=0. clr_ovrflw -> overflow=0.
  - FIFO full; load_buffer and Rd_en in the same cycle -> level stays 4, overflow stays 0, new frame is the last entry popped.
  - load_buffer after 6 shifts -> frame_err=1. Rd_en on an empty FIFO -> no change, level=0.
  - Pull reset_n low mid-frame with 3 entries held -> all outputs 0 immediately. A fresh 8-bit frame after release pushes correctly.
